// File: rtl/rom_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_arb_pkg
// Description : Shared types and constants for the two-port ROM arbiter:
//               FSM state encoding and requester port identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_arb_pkg;

  // Arbiter FSM states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Requester identifiers
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DBG   = 1'b1;

endpackage : rom_arb_pkg
`default_nettype wire

// File: rtl/rom_arbiter2_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Two-way round-robin winner selection. A lone requester wins;
//               on a tie the port that was not granted last time wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
  import rom_arb_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_valid
);

  // One-hot grant: tie goes to the port opposite last_grant
  always_comb begin
    grant       = 2'b00;
    grant[0]    = valid0 && (!valid1 || (last_grant == PORT_DBG));
    grant[1]    = valid1 && (!valid0 || (last_grant == PORT_FETCH));
    grant_valid = valid0 || valid1;
  end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/rom_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rom_arbiter2
// Description : Shares one combinational-read word memory between an
//               instruction-fetch port (0) and a debug/data port (1). One
//               transaction in flight; registered response held until the
//               owning requester accepts it. Round-robin on ties.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_arbiter2 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  // port 0 (instruction fetch)
  input  logic              req0_valid,
  input  logic [31:0]       req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_err,
  input  logic              rsp0_ready,
  // port 1 (debug / loader)
  input  logic              req1_valid,
  input  logic [31:0]       req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_err,
  input  logic              rsp1_ready,
  // memory
  output logic [31:0]       mem_a,
  input  logic [DATA_W-1:0] mem_rd
);

  import rom_arb_pkg::*;

  state_t              state;
  state_t              state_nxt;
  logic                last_grant;
  logic                owner;
  logic [31:0]         lat_addr;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_err_q;
  logic [1:0]          grant;
  logic                grant_valid;
  logic                accept;
  logic                out_of_range;
  logic                owner_rsp_ready;

  rr_pick2 u_pick (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Any significant bit above the memory depth means the word does not exist
  assign out_of_range    = |lat_addr[31:ADDR_W];
  assign owner_rsp_ready = (owner == PORT_FETCH) ? rsp0_ready : rsp1_ready;

  // Next-state logic and request handshakes; ready only ever asserted in IDLE
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state)
      S_IDLE: begin
        req0_ready = grant[0] && req0_valid;
        req1_ready = grant[1] && req1_valid;
        accept     = grant_valid;
        if (grant_valid) state_nxt = S_READ;
      end
      S_READ: state_nxt = S_RESP;
      S_RESP: if (owner_rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Request latch on accept, response capture at the end of READ
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PORT_DBG;
      owner      <= PORT_FETCH;
      lat_addr   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        lat_addr   <= grant[1] ? req1_addr : req0_addr;
        owner      <= grant[1];
        last_grant <= grant[1];
      end
      if (state == S_READ) begin
        rsp_data_q <= out_of_range ? '0 : mem_rd;
        rsp_err_q  <= out_of_range;
      end
    end
  end

  // Response valid only for the owner while the response is held
  assign rsp0_valid = (state == S_RESP) && (owner == PORT_FETCH);
  assign rsp1_valid = (state == S_RESP) && (owner == PORT_DBG);
  assign rsp0_data  = rsp_data_q;
  assign rsp1_data  = rsp_data_q;
  assign rsp0_err   = rsp_err_q;
  assign rsp1_err   = rsp_err_q;
  assign mem_a      = (state == S_IDLE) ? 32'd0 : lat_addr;

endmodule : rom_arbiter2
`default_nettype wire
